// File: rtl/game_pkg.sv
// Shared FSM encoding and edge-flag layout for the sprite controller.
package game_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCalc   = 2'd1,
    StCommit = 2'd2
  } sprite_state_e;

  // sprite_hit_edge is {left, right, top, bottom}
  localparam int unsigned EDGE_W      = 4;
  localparam int unsigned EDGE_LEFT   = 3;
  localparam int unsigned EDGE_RIGHT  = 2;
  localparam int unsigned EDGE_TOP    = 1;
  localparam int unsigned EDGE_BOTTOM = 0;

  localparam int unsigned DIV_W = 8;

endpackage

// File: rtl/game_sprite_axis.sv
// One axis of sprite motion: latches pos+speed in CALC and resolves the screen edge for COMMIT.
// GAME_SPRITE_BOUNCE_EN selects clamp-and-reflect; otherwise the axis wraps around.
module game_sprite_axis #(
  parameter int unsigned POS_W = 10,
  parameter int unsigned D_W   = 2,
  parameter int unsigned LIMIT = 640,
  parameter int unsigned SPAN  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_calc,
  input  logic [POS_W-1:0] i_pos,
  input  logic [D_W-1:0]   i_d,
  output logic [POS_W-1:0] o_pos,
  output logic [D_W-1:0]   o_d,
  output logic             o_lo,
  output logic             o_hi
);

  localparam int unsigned W = POS_W + 1;
  localparam logic signed [W-1:0] ZERO = '0;

  if (SPAN > LIMIT) begin : g_bad_span
    $error("sprite span exceeds screen extent");
  end

`ifdef GAME_SPRITE_BOUNCE_EN
  localparam logic signed [W-1:0] HI_LIM = W'(LIMIT - SPAN);
  localparam logic [D_W-1:0]      D_ZERO = '0;
  localparam logic [D_W-1:0]      D_MIN  = {1'b1, {(D_W-1){1'b0}}};
  localparam logic [D_W-1:0]      D_MAX  = ~D_MIN;
`else
  localparam logic signed [W-1:0] LIM = W'(LIMIT);
`endif

  logic signed [W-1:0] r_nx;
  logic signed [W-1:0] w_sum;

  assign w_sum = $signed({1'b0, i_pos}) + $signed({{(W-D_W){i_d[D_W-1]}}, i_d});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_nx <= '0;
    end else if (i_calc) begin
      r_nx <= w_sum;
    end
  end

  // Reflection acts on the speed held at COMMIT, and only when it points into the edge.
  always_comb begin
    o_pos = POS_W'(r_nx);
    o_d   = i_d;
    o_lo  = 1'b0;
    o_hi  = 1'b0;
`ifdef GAME_SPRITE_BOUNCE_EN
    if (r_nx <= ZERO) begin
      o_lo  = 1'b1;
      o_pos = '0;
      if (i_d[D_W-1]) begin
        o_d = (i_d == D_MIN) ? D_MAX : D_ZERO - i_d;
      end
    end else if (r_nx >= HI_LIM) begin
      o_hi  = 1'b1;
      o_pos = POS_W'(HI_LIM);
      if (!i_d[D_W-1] && (i_d != D_ZERO)) begin
        o_d = D_ZERO - i_d;
      end
    end
`else
    if (r_nx < ZERO) begin
      o_lo  = 1'b1;
      o_pos = POS_W'(r_nx + LIM);
    end else if (r_nx >= LIM) begin
      o_hi  = 1'b1;
      o_pos = POS_W'(r_nx - LIM);
    end
`endif
  end

endmodule

// File: rtl/game_sprite_control.sv
// Sprite motion controller: frame-tick divider, IDLE/CALC/COMMIT move FSM and host writes.
// Define GAME_SPRITE_BOUNCE_EN to clamp and reflect at screen edges instead of wrapping.
module game_sprite_control #(
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned SPRITE_WIDTH  = 8,
  parameter int unsigned SPRITE_HEIGHT = 8,
  parameter int unsigned X_WIDTH       = 10,
  parameter int unsigned Y_WIDTH       = 10,
  parameter int unsigned DX_WIDTH      = 2,
  parameter int unsigned DY_WIDTH      = 2,
  parameter int unsigned UPDATE_DIV    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sprite_write_xy,
  input  logic [X_WIDTH-1:0]  sprite_write_x,
  input  logic [Y_WIDTH-1:0]  sprite_write_y,
  input  logic                sprite_write_dxy,
  input  logic [DX_WIDTH-1:0] sprite_write_dx,
  input  logic [DY_WIDTH-1:0] sprite_write_dy,
  input  logic                sprite_enable_update,
  output logic [X_WIDTH-1:0]  sprite_x,
  output logic [Y_WIDTH-1:0]  sprite_y,
  output logic                sprite_we,
  output logic [3:0]          sprite_hit_edge
);
  import game_pkg::*;

  if (UPDATE_DIV < 1 || UPDATE_DIV > 255) begin : g_bad_div
    $error("UPDATE_DIV must be in 1..255");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(UPDATE_DIV - 1);

  sprite_state_e       r_state, w_state_next;
  logic [DIV_W-1:0]    r_div;
  logic [X_WIDTH-1:0]  r_x, w_x_new;
  logic [Y_WIDTH-1:0]  r_y, w_y_new;
  logic [DX_WIDTH-1:0] r_dx, w_dx_new;
  logic [DY_WIDTH-1:0] r_dy, w_dy_new;
  logic                r_we;
  logic [EDGE_W-1:0]   r_hit, w_hit;
  logic                w_calc;
  logic                w_x_lo, w_x_hi, w_y_lo, w_y_hi;

  assign w_calc = (r_state == StCalc);

  game_sprite_axis #(
    .POS_W(X_WIDTH),
    .D_W  (DX_WIDTH),
    .LIMIT(SCREEN_WIDTH),
    .SPAN (SPRITE_WIDTH)
  ) u_axis_x (
    .i_clk (clk),
    .i_rst (reset),
    .i_calc(w_calc),
    .i_pos (r_x),
    .i_d   (r_dx),
    .o_pos (w_x_new),
    .o_d   (w_dx_new),
    .o_lo  (w_x_lo),
    .o_hi  (w_x_hi)
  );

  game_sprite_axis #(
    .POS_W(Y_WIDTH),
    .D_W  (DY_WIDTH),
    .LIMIT(SCREEN_HEIGHT),
    .SPAN (SPRITE_HEIGHT)
  ) u_axis_y (
    .i_clk (clk),
    .i_rst (reset),
    .i_calc(w_calc),
    .i_pos (r_y),
    .i_d   (r_dy),
    .o_pos (w_y_new),
    .o_d   (w_dy_new),
    .o_lo  (w_y_lo),
    .o_hi  (w_y_hi)
  );

  always_comb begin
    w_hit              = '0;
    w_hit[EDGE_LEFT]   = w_x_lo;
    w_hit[EDGE_RIGHT]  = w_x_hi;
    w_hit[EDGE_TOP]    = w_y_lo;
    w_hit[EDGE_BOTTOM] = w_y_hi;
  end

  // A host position write aborts whatever move is in flight.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (sprite_enable_update && (r_div == DIV_LAST)) begin
          w_state_next = StCalc;
        end
      end
      StCalc:   w_state_next = StCommit;
      StCommit: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
    if (sprite_write_xy) begin
      w_state_next = StIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_div   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_we    <= 1'b0;
      r_hit   <= '0;
    end else begin
      r_state <= w_state_next;
      r_we    <= 1'b0;
      if (sprite_write_xy) begin
        r_x   <= sprite_write_x;
        r_y   <= sprite_write_y;
        r_we  <= 1'b1;
        r_hit <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (sprite_enable_update) begin
              r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
            end
          end
          StCommit: begin
            r_x   <= w_x_new;
            r_y   <= w_y_new;
            r_dx  <= w_dx_new;
            r_dy  <= w_dy_new;
            r_we  <= 1'b1;
            r_hit <= w_hit;
          end
          default: ;
        endcase
      end
      // A host speed write overrides any reflection committed in the same cycle.
      if (sprite_write_dxy) begin
        r_dx <= sprite_write_dx;
        r_dy <= sprite_write_dy;
      end
    end
  end

  assign sprite_x        = r_x;
  assign sprite_y        = r_y;
  assign sprite_we       = r_we;
  assign sprite_hit_edge = r_hit;

endmodule

// File: tb/tb_game_sprite_control.sv
// Randomised scoreboard bench for game_sprite_control against a cycle-stamped behavioural model.
// Honours GAME_SPRITE_BOUNCE_EN the same way the design does.
`timescale 1ns/1ps
module tb_game_sprite_control;
  import game_pkg::*;

  localparam int SW    = 640;
  localparam int SH    = 480;
  localparam int SPW   = 8;
  localparam int SPH   = 8;
  localparam int XW    = 10;
  localparam int YW    = 10;
  localparam int DXW   = 2;
  localparam int DYW   = 2;
  localparam int DIV   = 3;
  localparam int DXMAX = (1 << (DXW - 1)) - 1;
  localparam int DYMAX = (1 << (DYW - 1)) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           sprite_write_xy = 1'b0;
  logic [XW-1:0]  sprite_write_x = '0;
  logic [YW-1:0]  sprite_write_y = '0;
  logic           sprite_write_dxy = 1'b0;
  logic [DXW-1:0] sprite_write_dx = '0;
  logic [DYW-1:0] sprite_write_dy = '0;
  logic           sprite_enable_update = 1'b0;
  logic [XW-1:0]  sprite_x;
  logic [YW-1:0]  sprite_y;
  logic           sprite_we;
  logic [3:0]     sprite_hit_edge;

  game_sprite_control #(
    .SCREEN_WIDTH (SW),
    .SCREEN_HEIGHT(SH),
    .SPRITE_WIDTH (SPW),
    .SPRITE_HEIGHT(SPH),
    .X_WIDTH      (XW),
    .Y_WIDTH      (YW),
    .DX_WIDTH     (DXW),
    .DY_WIDTH     (DYW),
    .UPDATE_DIV   (DIV)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .sprite_write_xy     (sprite_write_xy),
    .sprite_write_x      (sprite_write_x),
    .sprite_write_y      (sprite_write_y),
    .sprite_write_dxy    (sprite_write_dxy),
    .sprite_write_dx     (sprite_write_dx),
    .sprite_write_dy     (sprite_write_dy),
    .sprite_enable_update(sprite_enable_update),
    .sprite_x            (sprite_x),
    .sprite_y            (sprite_y),
    .sprite_we           (sprite_we),
    .sprite_hit_edge     (sprite_hit_edge)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         x;
    int         y;
    logic [3:0] hit;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   we_count = 0;

  // Reference state: architectural position/speed plus at most one move awaiting commit.
  int         m_x, m_y, m_dx, m_dy, m_div;
  bit         p_valid;
  int         p_x, p_y, p_at;
  logic [3:0] p_hit;

  function automatic void axis_move(input int p, input int d, input int lim, input int span,
                                    output int np, output bit lo, output bit hi);
    np = p + d;
    lo = 1'b0;
    hi = 1'b0;
`ifdef GAME_SPRITE_BOUNCE_EN
    if (np <= 0) begin
      np = 0;
      lo = 1'b1;
    end else if (np >= lim - span) begin
      np = lim - span;
      hi = 1'b1;
    end
`else
    if (np < 0) begin
      np = np + lim;
      lo = 1'b1;
    end else if (np >= lim) begin
      np = np - lim;
      hi = 1'b1;
    end
`endif
  endfunction

  function automatic int reflect(input int d, input bit lo, input bit hi, input int dmax);
`ifdef GAME_SPRITE_BOUNCE_EN
    if (lo && d < 0) return (-d > dmax) ? dmax : -d;
    if (hi && d > 0) return -d;
`endif
    return d;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and advance the reference model for that cycle.
  task automatic step(input bit xy, input int x, input int y, input bit dxy, input int dx,
                      input int dy, input bit tick);
    bit   busy;
    bit   xlo, xhi, ylo, yhi;
    exp_t e;
    @(posedge clk);
    #1;
    sprite_write_xy      = xy;
    sprite_write_x       = XW'(x);
    sprite_write_y       = YW'(y);
    sprite_write_dxy     = dxy;
    sprite_write_dx      = DXW'(dx);
    sprite_write_dy      = DYW'(dy);
    sprite_enable_update = tick;
    busy = p_valid;
    if (xy) begin
      p_valid = 1'b0;
      m_x = x;
      m_y = y;
      e.x = x; e.y = y; e.hit = 4'b0000; e.at = cyc + 1;
      exp_q.push_back(e);
    end else if (p_valid && cyc == p_at) begin
      p_valid = 1'b0;
      m_x  = p_x;
      m_y  = p_y;
      m_dx = reflect(m_dx, p_hit[3], p_hit[2], DXMAX);
      m_dy = reflect(m_dy, p_hit[1], p_hit[0], DYMAX);
      e.x = p_x; e.y = p_y; e.hit = p_hit; e.at = cyc + 1;
      exp_q.push_back(e);
    end
    if (dxy) begin
      m_dx = dx;
      m_dy = dy;
    end
    if (tick && !xy && !busy) begin
      m_div++;
      if (m_div == DIV) begin
        m_div   = 0;
        p_valid = 1'b1;
        p_at    = cyc + 2;
        axis_move(m_x, m_dx, SW, SPW, p_x, xlo, xhi);
        axis_move(m_y, m_dy, SH, SPH, p_y, ylo, yhi);
        p_hit = {xlo, xhi, ylo, yhi};
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic tick_until_accept();
    int guard = 0;
    do begin
      step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
      guard++;
    end while (!p_valid && guard < 2 * DIV + 4);
    if (!p_valid) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accepted tick, expected one within %0d", guard);
    end
  endtask

  task automatic move_now();
    tick_until_accept();
    idle(4);
  endtask

  // Monitor: every write pulse must match the next expected entry, at its stamped cycle.
  initial begin
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    exp_t          e;
    px = '0;
    py = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if (sprite_we === 1'b1) begin
          we_count++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_we: got pulse x=%0d y=%0d at cyc %0d, expected none",
                     sprite_x, sprite_y, cyc);
          end else begin
            e = exp_q.pop_front();
            if (sprite_x !== XW'(e.x) || sprite_y !== YW'(e.y) || sprite_hit_edge !== e.hit ||
                cyc != e.at) begin
              errors++;
              $display("FAIL scoreboard: got x=%0d y=%0d hit=%b cyc=%0d, expected x=%0d y=%0d hit=%b cyc=%0d",
                       sprite_x, sprite_y, sprite_hit_edge, cyc, e.x, e.y, e.hit, e.at);
            end
          end
        end else begin
          checks++;
          if (sprite_we !== 1'b0 || sprite_x !== px || sprite_y !== py) begin
            errors++;
            $display("FAIL silent_change: got x=%0d y=%0d we=%b, expected x=%0d y=%0d we=0",
                     sprite_x, sprite_y, sprite_we, px, py);
          end
        end
        if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_we: got no pulse by cyc %0d, expected x=%0d y=%0d at cyc %0d",
                   cyc, exp_q[0].x, exp_q[0].y, exp_q[0].at);
          void'(exp_q.pop_front());
        end
      end
      px = sprite_x;
      py = sprite_y;
    end
  end

  task automatic model_reset();
    p_valid = 1'b0;
    m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_div = 0;
    exp_q.delete();
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 99) < 4, int'($urandom_range(0, SW - 1)),
           int'($urandom_range(0, SH - 1)), $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 3)) - 2, int'($urandom_range(0, 3)) - 2,
           $urandom_range(0, 9) < 4);
    end
  endtask

  int base;

  initial begin
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_x", int'(sprite_x), 0);
    check("reset_y", int'(sprite_y), 0);
    check("reset_we", int'(sprite_we), 0);
    check("reset_hit", int'(sprite_hit_edge), 0);
    reset = 1'b0;

    // Divider: only every third tick moves.
    base = we_count;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
      idle(4);
      check($sformatf("div_pulses_after_tick%0d", i), we_count - base, i / 3);
    end

    // Load and move by (+1,-1).
    step(1'b1, 100, 50, 1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1, -1, 1'b0);
    idle(2);
    base = we_count;
    move_now();
    check("load_move_x", int'(sprite_x), 101);
    check("load_move_y", int'(sprite_y), 49);
    check("load_move_we", we_count - base, 1);

    // Zero speed still pulses.
    step(1'b0, 0, 0, 1'b1, 0, 0, 1'b0);
    base = we_count;
    move_now();
    check("zero_speed_x", int'(sprite_x), 101);
    check("zero_speed_we", we_count - base, 1);

`ifdef GAME_SPRITE_BOUNCE_EN
    step(1'b1, 631, 100, 1'b1, 1, 0, 1'b0);
    idle(2);
    move_now();
    check("bounce_x", int'(sprite_x), 632);
    check("bounce_hit", int'(sprite_hit_edge), 4);
    move_now();
    check("bounce_back_x", int'(sprite_x), 631);
    check("bounce_dx", int'($signed(dut.r_dx)), -1);
`else
    step(1'b1, 0, 100, 1'b1, -1, 0, 1'b0);
    idle(2);
    move_now();
    check("wrap_left_x", int'(sprite_x), 639);
    check("wrap_left_hit", int'(sprite_hit_edge), 8);
    step(1'b1, 5, 0, 1'b1, 0, -1, 1'b0);
    idle(2);
    move_now();
    check("wrap_top_y", int'(sprite_y), 479);
    check("wrap_top_hit", int'(sprite_hit_edge), 2);
`endif

    // Host write lands in the COMMIT cycle of a move.
    step(1'b1, 200, 200, 1'b1, 1, 1, 1'b0);
    idle(2);
    base = we_count;
    tick_until_accept();
    idle(1);
    step(1'b1, 10, 10, 1'b0, 0, 0, 1'b0);
    idle(4);
    check("collide_x", int'(sprite_x), 10);
    check("collide_y", int'(sprite_y), 10);
    check("collide_hit", int'(sprite_hit_edge), 0);
    check("collide_we", we_count - base, 1);

    random_phase(500);
    idle(4);

    // Reset asserted while the move is in CALC.
    tick_until_accept();
    @(posedge clk);
    #1;
    sprite_write_xy = 1'b0;
    sprite_write_dxy = 1'b0;
    sprite_enable_update = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("calc_reset_x", int'(sprite_x), 0);
    check("calc_reset_y", int'(sprite_y), 0);
    check("calc_reset_we", int'(sprite_we), 0);
    check("calc_reset_hit", int'(sprite_hit_edge), 0);
    check("calc_reset_state", int'(dut.r_state), int'(StIdle));
    model_reset();
    base = we_count;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(6);
    check("calc_reset_no_we", we_count - base, 0);
    move_now();
    check("post_reset_move_we", we_count - base, 1);
    check("post_reset_move_x", int'(sprite_x), 0);

    random_phase(200);
    idle(6);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sprite_control.md
GAME_SPRITE_CONTROL -- requirements
Module: game_sprite_control

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 640, which is the visible width in pixels.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 480, which is the visible height in pixels.
REQ-003 SHALL have parameter SPRITE_WIDTH, default 8, which is the sprite width in pixels.
REQ-004 SHALL have parameter SPRITE_HEIGHT, default 8, which is the sprite height in pixels.
REQ-005 SHALL have parameter X_WIDTH, default 10, which is the X coordinate width in bits.
REQ-006 SHALL have parameter Y_WIDTH, default 10, which is the Y coordinate width in bits.
REQ-007 SHALL have parameter DX_WIDTH, default 2, which is the signed X speed width in bits.
REQ-008 SHALL have parameter DY_WIDTH, default 2, which is the signed Y speed width in bits.
REQ-009 SHALL have parameter UPDATE_DIV, default 1, which is the number of frame ticks per move (range 1..255).
REQ-010 SHALL have port clk, input, 1 bit, which is the single clock; all logic is on its rising edge.
REQ-011 SHALL have port reset, input, 1 bit, which is the asynchronous, active-high reset.
REQ-012 SHALL have port sprite_write_xy, input, 1 bit, which loads the position registers when high.
REQ-013 SHALL have port sprite_write_x, input, X_WIDTH bits, which is the position X to load.
REQ-014 SHALL have port sprite_write_y, input, Y_WIDTH bits, which is the position Y to load.
REQ-015 SHALL have port sprite_write_dxy, input, 1 bit, which loads the speed registers when high.
REQ-016 SHALL have port sprite_write_dx, input, DX_WIDTH bits, which is the signed X speed to load.
REQ-017 SHALL have port sprite_write_dy, input, DY_WIDTH bits, which is the signed Y speed to load.
REQ-018 SHALL have port sprite_enable_update, input, 1 bit, which is a one-cycle frame tick (end of visible frame).
REQ-019 SHALL have port sprite_x, output, X_WIDTH bits, a registered position that feeds the display block's sprite_x.
REQ-020 SHALL have port sprite_y, output, Y_WIDTH bits, a registered position that feeds the display block's sprite_y.
REQ-021 SHALL have port sprite_we, output, 1 bit, a one-cycle pulse when sprite_x/sprite_y take a new value.
REQ-022 SHALL have port sprite_hit_edge, output, 4 bits, {left,right,top,bottom}, latched at the last move.

Function
REQ-023 SHALL implement FSM IDLE -> CALC -> COMMIT -> IDLE, one cycle per state outside IDLE.
REQ-024 SHALL leave IDLE on sprite_enable_update only when the tick divider reaches UPDATE_DIV-1; otherwise it increments the divider and stays in IDLE.
REQ-025 SHALL in CALC register nx = x + sext(dx) and ny = y + sext(dy), each one bit wider than its coordinate and signed.
REQ-026 SHALL in COMMIT update sprite_x/sprite_y, pulse sprite_we, and update sprite_hit_edge; tick at cycle N gives new position visible at N+2.
REQ-027 SHALL ignore sprite_enable_update while in CALC or COMMIT, without counting it in the divider.
REQ-028 SHALL on sprite_write_xy load position, pulse sprite_we the next cycle, clear sprite_hit_edge, abort any in-flight move, and return to IDLE.
REQ-029 SHALL on sprite_write_dxy load speed; if it coincides with CALC, the old speed is used for that move.
REQ-030 SHALL give sprite_write_xy priority when it coincides with COMMIT, and the move is dropped.
REQ-031 SHALL treat a zero speed as a normal move: sprite_we still pulses and the position is unchanged.

Reset
REQ-032 SHALL on reset set sprite_x=0, sprite_y=0, dx=0, dy=0, sprite_we=0, sprite_hit_edge=0, divider=0, and FSM=IDLE.
REQ-033 SHALL honour reset asserted mid-move immediately, with no write pulse emitted.

Configuration
REQ-034 SHALL, with GAME_SPRITE_BOUNCE_EN defined, clamp nx to [0, SCREEN_WIDTH-SPRITE_WIDTH] and ny to [0, SCREEN_HEIGHT-SPRITE_HEIGHT].
REQ-035 SHALL, with GAME_SPRITE_BOUNCE_EN defined, negate the offending speed at a clamp; negating the most negative value yields the most positive value.
REQ-036 SHALL, with GAME_SPRITE_BOUNCE_EN undefined, wrap: nx<0 -> nx+SCREEN_WIDTH and nx>=SCREEN_WIDTH -> nx-SCREEN_WIDTH (Y likewise); speed is unchanged and edge bits still flag the wrap side.

Structure
REQ-037 SHALL place the FSM state encoding and the edge-bit index constants in shared package game_pkg.
REQ-038 SHALL implement per-axis arithmetic in one sub-module, game_sprite_axis, instantiated twice (X and Y).

Verification
REQ-039 SHALL cover load: write_xy (100,50), write_dxy (+1,-1), one tick -> at tick+2 sprite_x=101, sprite_y=49, sprite_we pulses once.
REQ-040 SHALL cover bounce: with BOUNCE_EN, x=631, dx=+1, tick -> sprite_x=632 and right bit set; next tick -> x=631 and dx=-1.
REQ-041 SHALL cover wrap: without BOUNCE_EN, x=0, dx=-1, tick -> sprite_x=639 and left bit set.
REQ-042 SHALL cover divider: UPDATE_DIV=3, six ticks -> exactly two sprite_we pulses, after the 3rd and 6th ticks.
REQ-043 SHALL cover collision: write_xy (10,10) in the COMMIT cycle of a move -> sprite_x=10, sprite_y=10, and no stale position is ever output.
REQ-044 SHALL cover reset in CALC: outputs return to 0 immediately, no sprite_we, FSM=IDLE.
